// File: rtl/isr_sequencer.sv
// isr_sequencer: interrupt entry/return sequencer driving the single SPR write port
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_jisr, i_mca, i_rpt  accepted interrupt, masked cause vector, repeat-instruction flag
//   i_pc, i_next_pc, i_ea interrupted PC, following PC, effective address
//   i_sr_in               current SR value
//   i_rfe, i_abort        return-from-exception request, fatal abort
//   o_spr_we/sel/wdata    SPR write port (0 SR,1 ESR,2 ECA,3 EPC,4 EDPC,5 EDATA,6 MODE)
//   o_pc_load/pc_target   one-cycle fetch redirect
//   o_stall, o_mode, o_halted
module isr_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_jisr,
  input  logic [22:0] i_mca,
  input  logic        i_rpt,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_next_pc,
  input  logic [31:0] i_ea,
  input  logic [31:0] i_sr_in,
  input  logic        i_rfe,
  input  logic        i_abort,
  output logic        o_spr_we,
  output logic [2:0]  o_spr_sel,
  output logic [31:0] o_spr_wdata,
  output logic        o_pc_load,
  output logic [31:0] o_pc_target,
  output logic        o_stall,
  output logic [31:0] o_mode,
  output logic        o_halted
);
  localparam logic [31:0] SISR = 32'h0000_0100;
  typedef enum logic [3:0] {
    IDLE, SV_ESR, SV_ECA, SV_EPC, SV_EDPC, SV_EDATA, CLR_SR, SET_MODE, JMP,
    RFE_SR, RFE_MODE, RFE_JMP, HALT
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_esr, r_eca, r_epc, r_edpc, r_edata, r_emode, r_mode;
  logic        w_capture;
  // snapshot is taken only when the interrupt path actually starts (abort outranks jisr)
  assign w_capture = (r_state == IDLE) && i_jisr && !i_abort;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (i_abort) w_next = HALT;
    else
      case (r_state)
        IDLE:     w_next = i_jisr ? SV_ESR : (i_rfe ? RFE_SR : IDLE);
        SV_ESR:   w_next = SV_ECA;
        SV_ECA:   w_next = SV_EPC;
        SV_EPC:   w_next = SV_EDPC;
        SV_EDPC:  w_next = SV_EDATA;
        SV_EDATA: w_next = CLR_SR;
        CLR_SR:   w_next = SET_MODE;
        SET_MODE: w_next = JMP;
        JMP:      w_next = IDLE;
        RFE_SR:   w_next = RFE_MODE;
        RFE_MODE: w_next = RFE_JMP;
        RFE_JMP:  w_next = IDLE;
        HALT:     w_next = HALT;
        default:  w_next = IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_esr   <= '0;
      r_eca   <= '0;
      r_epc   <= '0;
      r_edpc  <= '0;
      r_edata <= '0;
      r_emode <= '0;
    end else if (w_capture) begin
      r_esr   <= i_sr_in;
      r_eca   <= {9'b0, i_mca};
      r_epc   <= i_rpt ? i_pc : i_next_pc;
      r_edpc  <= i_next_pc;
      r_edata <= i_ea;
      r_emode <= r_mode;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_mode <= '0;
    else if (r_state == SET_MODE) r_mode <= '0;
    else if (r_state == RFE_MODE) r_mode <= r_emode;
  always_comb begin
    o_spr_we    = 1'b0;
    o_spr_sel   = 3'd0;
    o_spr_wdata = '0;
    o_pc_load   = 1'b0;
    o_pc_target = '0;
    case (r_state)
      SV_ESR:   begin o_spr_we = 1'b1; o_spr_sel = 3'd1; o_spr_wdata = r_esr;   end
      SV_ECA:   begin o_spr_we = 1'b1; o_spr_sel = 3'd2; o_spr_wdata = r_eca;   end
      SV_EPC:   begin o_spr_we = 1'b1; o_spr_sel = 3'd3; o_spr_wdata = r_epc;   end
      SV_EDPC:  begin o_spr_we = 1'b1; o_spr_sel = 3'd4; o_spr_wdata = r_edpc;  end
      SV_EDATA: begin o_spr_we = 1'b1; o_spr_sel = 3'd5; o_spr_wdata = r_edata; end
      CLR_SR:   begin o_spr_we = 1'b1; o_spr_sel = 3'd0; end
      SET_MODE: begin o_spr_we = 1'b1; o_spr_sel = 3'd6; end
      JMP:      begin o_pc_load = 1'b1; o_pc_target = SISR; end
      RFE_SR:   begin o_spr_we = 1'b1; o_spr_sel = 3'd0; o_spr_wdata = r_esr;   end
      RFE_MODE: begin o_spr_we = 1'b1; o_spr_sel = 3'd6; o_spr_wdata = r_emode; end
      RFE_JMP:  begin o_pc_load = 1'b1; o_pc_target = r_epc; end
      default:  ;
    endcase
  end
  assign o_stall  = r_state != IDLE;
  assign o_halted = r_state == HALT;
  assign o_mode   = r_mode;
endmodule
